// File: rtl/dcache_ctrl_pkg.sv
// Shared types, field bounds and word helpers for the direct-mapped write-back data cache.
package dcache_ctrl_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BE_W           = WORD_W / 8;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int unsigned OFF_LSB        = 2;
  localparam int unsigned OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_LSB        = OFF_LSB + OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Select one word of a line; word0 sits in the least significant bits.
  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off);
    return line[off*WORD_W +: WORD_W];
  endfunction

  // Replace only the byte lanes enabled in be.
  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous line fill and byte-merged word store.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned TAG_W     = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic              o_rd_dirty,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_fill_en,
  input  logic [IDX_W-1:0]  i_fill_idx,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_line,
  input  logic              i_st_en,
  input  logic [IDX_W-1:0]  i_st_idx,
  input  logic [OFF_W-1:0]  i_st_off,
  input  logic [BE_W-1:0]   i_st_be,
  input  logic [WORD_W-1:0] i_st_wdata
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];
  logic [LINE_W-1:0]    w_st_line;

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

  // Stored line with the enabled byte lanes of one word replaced.
  always_comb begin
    w_st_line = r_data[i_st_idx];
    w_st_line[i_st_off*WORD_W +: WORD_W] =
      merge_word(get_word(r_data[i_st_idx], i_st_off), i_st_wdata, i_st_be);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
      r_dirty[i_fill_idx] <= 1'b0;
    end else if (i_st_en) begin
      r_dirty[i_st_idx] <= 1'b1;
    end
  end

  // Tags and data are intentionally left unreset; valid bits qualify them.
  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_line;
    end else if (i_st_en) begin
      r_data[i_st_idx] <= w_st_line;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: hit path, miss FSM
// (IDLE/WB/FILL/DONE) driving the line-wide D-memory bus, and hit/miss statistics.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned MEM_LAT   = 4,
  parameter int unsigned AWIDTH    = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [31:0]       CPU_ADDR,
  input  logic [3:0]        CPU_BE,
  input  logic [31:0]       CPU_WDATA,
  output logic [31:0]       CPU_RDATA,
  output logic              STALL,
  output logic              D_MEM_CSN,
  output logic              D_MEM_WEN,
  output logic [AWIDTH-1:0] D_MEM_ADDR,
  output logic [LINE_W-1:0] D_MEM_DOUT,
  input  logic [LINE_W-1:0] D_MEM_DI,
  output logic [31:0]       HIT_CNT,
  output logic [31:0]       MISS_CNT
);

  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = AWIDTH - IDX_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              r_state;
  logic [LAT_W-1:0]    r_lat;
  logic                r_replay;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [WORD_W-1:0]   r_wdata;
  logic [OFF_W-1:0]    r_off;
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic                r_csn;
  logic                r_wen;
  logic [AWIDTH-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_dout;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  logic                w_req;
  logic                w_we;
  logic [BE_W-1:0]     w_be;
  logic [WORD_W-1:0]   w_wdata;
  logic [OFF_W-1:0]    w_off;
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_idle;
  logic                w_hit;
  logic                w_miss;
  logic                w_lat_last;
  logic                w_fill_en;
  logic                w_st_en;
  logic                w_rd_valid;
  logic                w_rd_dirty;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [LINE_W-1:0]   w_rd_line;
  logic                w_unused_addr;

  assign w_unused_addr = ^{CPU_ADDR[31:AWIDTH+4], CPU_ADDR[OFF_LSB-1:0]};

  // The cycle after DONE replays the latched request instead of the live CPU inputs.
  assign w_req   = r_replay | CPU_REQ;
  assign w_we    = r_replay ? r_we    : CPU_WE;
  assign w_be    = r_replay ? r_be    : CPU_BE;
  assign w_wdata = r_replay ? r_wdata : CPU_WDATA;
  assign w_off   = r_replay ? r_off   : CPU_ADDR[OFF_LSB +: OFF_W];
  assign w_idx   = r_replay ? r_idx   : CPU_ADDR[IDX_LSB +: IDX_W];
  assign w_tag   = r_replay ? r_tag   : CPU_ADDR[TAG_LSB +: TAG_W];

  assign w_idle     = (r_state == ST_IDLE);
  assign w_hit      = w_idle & w_req & w_rd_valid & (w_rd_tag == w_tag);
  assign w_miss     = w_idle & w_req & ~w_hit;
  assign w_lat_last = (r_lat == LAT_W'(MEM_LAT - 1));
  assign w_fill_en  = (r_state == ST_FILL) & w_lat_last;
  assign w_st_en    = w_hit & w_we;

  assign STALL      = RSTn & (~w_idle | w_miss);
  assign CPU_RDATA  = get_word(w_rd_line, w_off);
  assign D_MEM_CSN  = r_csn;
  assign D_MEM_WEN  = r_wen;
  assign D_MEM_ADDR = r_mem_addr;
  assign D_MEM_DOUT = r_mem_dout;
  assign HIT_CNT    = r_hit_cnt;
  assign MISS_CNT   = r_miss_cnt;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .i_clk       (CLK),
    .i_rst_n     (RSTn),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_tag    (w_rd_tag),
    .o_rd_line   (w_rd_line),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (r_idx),
    .i_fill_tag  (r_tag),
    .i_fill_line (D_MEM_DI),
    .i_st_en     (w_st_en),
    .i_st_idx    (w_idx),
    .i_st_off    (w_off),
    .i_st_be     (w_be),
    .i_st_wdata  (w_wdata)
  );

  // Miss FSM with registered memory-bus outputs and statistics.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_lat      <= '0;
      r_replay   <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_off      <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_csn      <= 1'b1;
      r_wen      <= 1'b1;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_replay <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
          if (w_miss) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_we       <= w_we;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_off      <= w_off;
            r_idx      <= w_idx;
            r_tag      <= w_tag;
            r_lat      <= '0;
            r_csn      <= 1'b0;
            if (w_rd_valid && w_rd_dirty) begin
              r_state    <= ST_WB;
              r_wen      <= 1'b0;
              r_mem_addr <= {w_rd_tag, w_idx};
              r_mem_dout <= w_rd_line;
            end else begin
              r_state    <= ST_FILL;
              r_wen      <= 1'b1;
              r_mem_addr <= {w_tag, w_idx};
            end
          end
        end
        ST_WB: begin
          if (w_lat_last) begin
            r_state    <= ST_FILL;
            r_lat      <= '0;
            r_wen      <= 1'b1;
            r_mem_addr <= {r_tag, r_idx};
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        ST_FILL: begin
          if (w_lat_last) begin
            r_state <= ST_DONE;
            r_csn   <= 1'b1;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_replay <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic against an
// architectural memory model and a residency model of the direct-mapped cache.
module tb_dcache_ctrl;

  localparam int NL  = 16;
  localparam int LAT = 4;
  localparam int AW  = 10;
  localparam int NMEM = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [127:0]  data;
  } wb_t;

  logic          CLK;
  logic          RSTn;
  logic          CPU_REQ;
  logic          CPU_WE;
  logic [31:0]   CPU_ADDR;
  logic [3:0]    CPU_BE;
  logic [31:0]   CPU_WDATA;
  logic [31:0]   CPU_RDATA;
  logic          STALL;
  logic          D_MEM_CSN;
  logic          D_MEM_WEN;
  logic [AW-1:0] D_MEM_ADDR;
  logic [127:0]  D_MEM_DOUT;
  logic [127:0]  D_MEM_DI;
  logic [31:0]   HIT_CNT;
  logic [31:0]   MISS_CNT;

  int checks   = 0;
  int failures = 0;

  // Backing memory (as written by the DUT) and architectural truth (as the CPU sees it).
  logic [127:0] mem  [NMEM];
  logic [127:0] arch [NMEM];
  bit           m_valid [NL];
  bit           m_dirty [NL];
  int           m_tag   [NL];
  int           exp_hit;
  int           exp_miss;
  wb_t          wb_q[$];
  logic [AW-1:0] fill_q[$];
  logic         p_csn;
  logic         p_wen;

  dcache_ctrl #(.NUM_LINES(NL), .MEM_LAT(LAT), .AWIDTH(AW)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .CPU_REQ    (CPU_REQ),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_BE     (CPU_BE),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_RDATA  (CPU_RDATA),
    .STALL      (STALL),
    .D_MEM_CSN  (D_MEM_CSN),
    .D_MEM_WEN  (D_MEM_WEN),
    .D_MEM_ADDR (D_MEM_ADDR),
    .D_MEM_DOUT (D_MEM_DOUT),
    .D_MEM_DI   (D_MEM_DI),
    .HIT_CNT    (HIT_CNT),
    .MISS_CNT   (MISS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign D_MEM_DI = mem[D_MEM_ADDR];

  // Memory side: absorb write-backs and log the start of every transaction.
  always @(posedge CLK) begin
    if (!D_MEM_CSN) begin
      if (!D_MEM_WEN) mem[D_MEM_ADDR] <= D_MEM_DOUT;
      if (p_csn || (p_wen != D_MEM_WEN)) begin
        if (!D_MEM_WEN) wb_q.push_back({D_MEM_ADDR, D_MEM_DOUT});
        else            fill_q.push_back(D_MEM_ADDR);
      end
    end
    p_csn <= D_MEM_CSN;
    p_wen <= D_MEM_WEN;
  end

  task automatic apply_reset();
    CPU_REQ = 1'b0;
    RSTn    = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    for (int i = 0; i < NMEM; i++) arch[i] = mem[i];
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  // One CPU access held until STALL drops; compares timing, data, counters and bus traffic.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input string nm, output logic [31:0] got);
    int line, idx, tg, off, exp_stall, n, wb_sz, fill_sz, exp_wb_line;
    bit hit, do_wb;
    logic [31:0] exp_rd, w;
    logic [127:0] exp_wb_data;
    line = int'(addr[13:4]);
    idx  = line % NL;
    tg   = line / NL;
    off  = int'(addr[3:2]);
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    do_wb = !hit && m_valid[idx] && m_dirty[idx];
    exp_wb_line = m_tag[idx] * NL + idx;
    exp_wb_data = arch[exp_wb_line];
    exp_stall = hit ? 0 : (do_wb ? 2 * LAT + 2 : LAT + 2);
    exp_rd = arch[line][off*32 +: 32];
    wb_sz   = wb_q.size();
    fill_sz = fill_q.size();
    if (!hit) begin
      exp_miss++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    exp_hit++;
    if (we) begin
      w = exp_rd;
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      arch[line][off*32 +: 32] = w;
      m_dirty[idx] = 1'b1;
    end

    @(negedge CLK);
    CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_BE = be; CPU_WDATA = wd;
    #1;
    n = 0;
    while (STALL && n < 100) begin
      @(posedge CLK); #1;
      CPU_WE = 1'($urandom); CPU_ADDR = $urandom; CPU_BE = 4'($urandom); CPU_WDATA = $urandom;
      @(negedge CLK);
      CPU_WE = we; CPU_ADDR = addr; CPU_BE = be; CPU_WDATA = wd;
      #1;
      n++;
    end
    got = CPU_RDATA;
    @(posedge CLK); #1;
    CPU_REQ = 1'b0;

    checks++;
    if (n != exp_stall) begin
      failures++;
      $display("FAIL %s stall_cycles addr=%h got=%0d exp=%0d", nm, addr, n, exp_stall);
    end
    if (!we) begin
      checks++;
      if (got !== exp_rd) begin
        failures++;
        $display("FAIL %s rdata addr=%h got=%h exp=%h", nm, addr, got, exp_rd);
      end
    end
    checks++;
    if (HIT_CNT !== 32'(exp_hit) || MISS_CNT !== 32'(exp_miss)) begin
      failures++;
      $display("FAIL %s counters got hit=%0d miss=%0d exp hit=%0d miss=%0d",
               nm, HIT_CNT, MISS_CNT, exp_hit, exp_miss);
    end
    checks++;
    if (do_wb) begin
      if (wb_q.size() != wb_sz + 1) begin
        failures++;
        $display("FAIL %s writeback_count got=%0d exp=%0d", nm, wb_q.size() - wb_sz, 1);
      end else if (wb_q[$].addr !== AW'(exp_wb_line) || wb_q[$].data !== exp_wb_data) begin
        failures++;
        $display("FAIL %s writeback got addr=%h data=%h exp addr=%h data=%h",
                 nm, wb_q[$].addr, wb_q[$].data, AW'(exp_wb_line), exp_wb_data);
      end
    end else if (wb_q.size() != wb_sz) begin
      failures++;
      $display("FAIL %s writeback_count got=%0d exp=0", nm, wb_q.size() - wb_sz);
    end
    checks++;
    if (!hit) begin
      if (fill_q.size() != fill_sz + 1 || fill_q[$] !== AW'(line)) begin
        failures++;
        $display("FAIL %s fill got count=%0d exp count=1 line=%h", nm, fill_q.size() - fill_sz,
                 AW'(line));
      end
    end else if (fill_q.size() != fill_sz) begin
      failures++;
      $display("FAIL %s fill_count got=%0d exp=0", nm, fill_q.size() - fill_sz);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (STALL !== 1'b0 || D_MEM_CSN !== 1'b1 || D_MEM_WEN !== 1'b1 || D_MEM_ADDR !== '0 ||
        D_MEM_DOUT !== '0 || HIT_CNT !== 32'd0 || MISS_CNT !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got stall=%b csn=%b wen=%b addr=%h dout_nz=%b hit=%0d miss=%0d exp 0 1 1 0 0 0 0",
               STALL, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, |D_MEM_DOUT, HIT_CNT, MISS_CNT);
    end
  endtask

  task automatic test_cold_load();
    logic [31:0] got;
    access(1'b0, 32'h100, 4'h0, 32'h0, "cold_load", got);
    checks++;
    if (got !== 32'h1 || MISS_CNT !== 32'd1 || HIT_CNT !== 32'd1) begin
      failures++;
      $display("FAIL cold_load_direct got rdata=%h miss=%0d hit=%0d exp 1 1 1", got, MISS_CNT, HIT_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g1, g2;
    access(1'b0, 32'h104, 4'h0, 32'h0, "b2b_0", g1);
    access(1'b0, 32'h10C, 4'h0, 32'h0, "b2b_1", g2);
    checks++;
    if (g1 !== 32'h2 || g2 !== 32'h4 || HIT_CNT !== 32'd3) begin
      failures++;
      $display("FAIL back_to_back got %h %h hit=%0d exp 2 4 3", g1, g2, HIT_CNT);
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] got;
    access(1'b1, 32'h100, 4'b0011, 32'hAABBCCDD, "store_hit", got);
    access(1'b0, 32'h100, 4'h0, 32'h0, "store_hit_rd", got);
    checks++;
    if (got !== 32'h0000CCDD) begin
      failures++;
      $display("FAIL store_hit_merge got=%h exp=0000ccdd", got);
    end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] got;
    access(1'b0, 32'h200, 4'h0, 32'h0, "dirty_evict", got);
    checks++;
    if (wb_q.size() == 0 || wb_q[$].addr !== AW'(16'h10) || wb_q[$].data[31:0] !== 32'h0000CCDD) begin
      failures++;
      $display("FAIL dirty_evict_wb got wbs=%0d exp line 010 word0 0000ccdd", wb_q.size());
    end
  endtask

  task automatic test_store_miss();
    logic [31:0] got;
    access(1'b1, 32'h304, 4'hF, 32'h12345678, "store_miss", got);
    access(1'b0, 32'h000, 4'h0, 32'h0, "store_miss_evict", got);
    checks++;
    if (wb_q.size() == 0 || wb_q[$].addr !== AW'(16'h30) || wb_q[$].data[63:32] !== 32'h12345678) begin
      failures++;
      $display("FAIL store_miss_wb got wbs=%0d exp line 030 word1 12345678", wb_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] got, addr;
    for (int i = 0; i < 150; i++) begin
      addr = {18'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'b00};
      access(1'($urandom), addr, 4'($urandom), $urandom, "random", got);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] got;
    apply_reset();
    @(negedge CLK);
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h100; CPU_BE = 4'h0;
    #1;
    checks++;
    if (STALL !== 1'b1) begin
      failures++;
      $display("FAIL rst_fill_miss_stall got=%b exp=1", STALL);
    end
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (D_MEM_CSN !== 1'b0 || D_MEM_WEN !== 1'b1) begin
      failures++;
      $display("FAIL rst_fill_in_fill got csn=%b wen=%b exp 0 1", D_MEM_CSN, D_MEM_WEN);
    end
    RSTn = 1'b0;
    #1;
    checks++;
    if (D_MEM_CSN !== 1'b1 || STALL !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill_abort got csn=%b stall=%b exp 1 0", D_MEM_CSN, STALL);
    end
    CPU_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < NMEM; i++) arch[i] = mem[i];
    exp_hit  = 0;
    exp_miss = 0;
    access(1'b0, 32'h100, 4'h0, 32'h0, "rst_fill_reload", got);
    checks++;
    if (MISS_CNT !== 32'd1 || got !== mem[16][31:0]) begin
      failures++;
      $display("FAIL rst_fill_reload_direct got miss=%0d rdata=%h exp 1 %h", MISS_CNT, got, mem[16][31:0]);
    end
  endtask

  initial begin
    RSTn = 1'b0; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_BE = '0; CPU_WDATA = '0;
    for (int i = 0; i < NMEM; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[16] = {32'h4, 32'h3, 32'h2, 32'h1};
    apply_reset();
    test_reset();
    test_cold_load();
    test_back_to_back();
    test_store_hit();
    test_dirty_evict();
    test_store_miss();
    test_random();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
